// File: rtl/seg7_scan_driver_if.sv
// Bus between a display controller and the eight-digit multiplexed 7-segment scan driver.
// The controller side writes display data; the driver side returns the registered panel drives.
interface seg7_scan_driver_if;
  logic [31:0] i_data;
  logic        i_we;
  logic        i_lzb;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  modport master (
    output i_data, i_we, i_lzb,
    input  o_seg, o_sel, o_frame
  );

  modport slave (
    input  i_data, i_we, i_lzb,
    output o_seg, o_sel, o_frame
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment scanner: holds each digit for SCAN_DIV clocks,
// decodes hex to active-low segments with optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk_in,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [31:0]      disp_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       index_q;
  logic             frame_pend_q;
  logic [7:0]       seg_q;
  logic [7:0]       sel_q;
  logic             frame_q;

  logic             div_wrap;
  logic [3:0]       nibble;
  logic [7:0]       upper_zero;
  logic             blank;
  logic [7:0]       seg_next;
  logic [7:0]       sel_next;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    upper_zero = '0;
    // upper_zero[i]: nibbles i..7 are all zero, i.e. digit i is a leading zero.
    for (int i = 0; i < 8; i++) begin
      upper_zero[i] = ((disp_q >> (4 * i)) == 32'h0);
    end
    nibble   = disp_q[{index_q, 2'b00} +: 4];
    blank    = bus.i_lzb && (index_q != 3'd0) && upper_zero[index_q];
    seg_next = blank ? 8'hFF : hex_to_seg(nibble);
    sel_next = ~(8'h01 << index_q);
  end

  // Outputs are formed from pre-edge index/data, so a write landing on a digit
  // advance shows the old nibble for one edge and the new one afterwards.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      disp_q       <= '0;
      div_q        <= '0;
      index_q      <= '0;
      frame_pend_q <= 1'b0;
      seg_q        <= 8'hFF;
      sel_q        <= 8'hFF;
      frame_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (bus.i_we) disp_q <= bus.i_data;
      div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) index_q <= index_q + 3'd1;
      frame_pend_q <= div_wrap && (index_q == 3'd7);
      seg_q        <= seg_next;
      sel_q        <= sel_next;
      frame_q      <= frame_pend_q;
    end
  end

  assign bus.o_seg   = seg_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_frame = frame_q;

endmodule
